// File: rtl/mc_line_xfer_pkg.sv
// Shared memcache definitions: controller port widths, line-transfer FSM states
// and the burst-length helper used when issuing a line command.
package mc_line_xfer_pkg;

  localparam int MI_LEN_W  = 7;
  localparam int MI_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } xferState_e;

  // The controller performs len+1 beats, so a line of 2^lw words needs 2^lw-1.
  function automatic logic [MI_LEN_W-1:0] mcLen(input int unsigned lw);
    int unsigned beats;
    beats = (32'd1 << lw) - 32'd1;
    return beats[MI_LEN_W-1:0];
  endfunction

endpackage

// File: rtl/mc_line_xfer_buf.sv
// Line buffer: one write port (client or controller, muxed by the parent), a
// combinational read port feeding write bursts and a registered client read port.
module mc_line_buf
  import mc_line_xfer_pkg::*;
#(
  parameter int LW = 3
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [LW-1:0]        waddr_i,
  input  logic [MI_DATA_W-1:0] wdata_i,
  input  logic [LW-1:0]        craddr_i,
  output logic [MI_DATA_W-1:0] crdata_o,
  input  logic [LW-1:0]        raddr_i,
  output logic [MI_DATA_W-1:0] rdata_o
);

  logic [MI_DATA_W-1:0] mem_q [2**LW];
  logic [MI_DATA_W-1:0] rdata_q;

  // Read samples the array before this edge's write lands, so same-address
  // read/write returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign crdata_o = mem_q[craddr_i];
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/mc_line_xfer.sv
// Moves one cache line between the local line buffer and the memory controller,
// checking beat/last-flag protocol and flagging violations on a sticky err.
module mc_line_xfer
  import mc_line_xfer_pkg::*;
#(
  parameter int AW = 20,
  parameter int LW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-LW-1:0]     req_addr,
  input  logic                 req_rw,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  input  logic [LW-1:0]        buf_waddr,
  input  logic [MI_DATA_W-1:0] buf_wdata,
  input  logic                 buf_we,
  input  logic [LW-1:0]        buf_raddr,
  output logic [MI_DATA_W-1:0] buf_rdata,
  output logic [AW-1:0]        mi_addr,
  output logic [MI_LEN_W-1:0]  mi_len,
  output logic                 mi_rw,
  output logic                 mi_valid,
  input  logic                 mi_ready,
  output logic [MI_DATA_W-1:0] mi_wdata,
  input  logic                 mi_wack,
  input  logic                 mi_wlast,
  input  logic [MI_DATA_W-1:0] mi_rdata,
  input  logic                 mi_rstb,
  input  logic                 mi_rlast
);

  localparam logic [LW:0] LAST_BEAT = (LW+1)'((1 << LW) - 1);

  xferState_e           state_q, state_d;
  logic [LW:0]          beatCnt_q, beatCnt_d;
  logic [AW-LW-1:0]     lineAddr_q, lineAddr_d;
  logic                 rw_q, rw_d;
  logic                 err_q, err_d;

  logic                 isFinal;
  logic                 errEvent;
  logic                 bufWe;
  logic [LW-1:0]        bufWaddr;
  logic [MI_DATA_W-1:0] bufWdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beatCnt_q  <= '0;
      lineAddr_q <= '0;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      lineAddr_q <= lineAddr_d;
      rw_q       <= rw_d;
      err_q      <= err_d;
    end
  end

  // A beat whose last flag disagrees with its position is rejected outright:
  // no buffer write, no count, no state change.
  always_comb begin
    state_d    = state_q;
    beatCnt_d  = beatCnt_q;
    lineAddr_d = lineAddr_q;
    rw_d       = rw_q;
    errEvent   = 1'b0;
    bufWe      = 1'b0;
    bufWaddr   = buf_waddr;
    bufWdata   = buf_wdata;
    isFinal    = (beatCnt_q == LAST_BEAT);

    unique case (state_q)
      ST_IDLE: begin
        errEvent = mi_rstb | mi_wack;
        bufWe    = buf_we;
        if (req_valid) begin
          state_d    = ST_CMD;
          lineAddr_d = req_addr;
          rw_d       = req_rw;
          beatCnt_d  = '0;
        end
      end
      ST_CMD: begin
        errEvent = mi_rstb | mi_wack;
        if (mi_ready) begin
          state_d = rw_q ? ST_RDATA : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (mi_wack) begin
          if (mi_wlast != isFinal) begin
            errEvent = 1'b1;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
            if (isFinal) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_RDATA: begin
        if (mi_rstb) begin
          if (mi_rlast != isFinal) begin
            errEvent = 1'b1;
          end else begin
            bufWe     = 1'b1;
            bufWaddr  = beatCnt_q[LW-1:0];
            bufWdata  = mi_rdata;
            beatCnt_d = beatCnt_q + 1'b1;
            if (isFinal) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        errEvent = mi_rstb | mi_wack;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (errEvent) begin
      err_d = 1'b1;
    end
  end

  mc_line_buf #(
    .LW(LW)
  ) u_buf (
    .clk      (clk),
    .we_i     (bufWe),
    .waddr_i  (bufWaddr),
    .wdata_i  (bufWdata),
    .craddr_i (beatCnt_q[LW-1:0]),
    .crdata_o (mi_wdata),
    .raddr_i  (buf_raddr),
    .rdata_o  (buf_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign mi_valid  = (state_q == ST_CMD);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign mi_addr   = {lineAddr_q, {LW{1'b0}}};
  assign mi_len    = mcLen(LW);
  assign mi_rw     = rw_q;

endmodule

// File: tb/tb_mc_line_xfer.sv
// Directed-plus-random bench for mc_line_xfer: the bench plays the memory
// controller and keeps its own model of the line buffer and memory contents.
module tb_mc_line_xfer;

  localparam int AW    = 20;
  localparam int LW    = 3;
  localparam int WORDS = 8;

  logic              clk;
  logic              rst;
  logic [AW-LW-1:0]  req_addr;
  logic              req_rw;
  logic              req_valid;
  logic              req_ready;
  logic              done;
  logic              err;
  logic              err_clr;
  logic [LW-1:0]     buf_waddr;
  logic [31:0]       buf_wdata;
  logic              buf_we;
  logic [LW-1:0]     buf_raddr;
  logic [31:0]       buf_rdata;
  logic [AW-1:0]     mi_addr;
  logic [6:0]        mi_len;
  logic              mi_rw;
  logic              mi_valid;
  logic              mi_ready;
  logic [31:0]       mi_wdata;
  logic              mi_wack;
  logic              mi_wlast;
  logic [31:0]       mi_rdata;
  logic              mi_rstb;
  logic              mi_rlast;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] refBuf [WORDS];
  logic [31:0] memModel [int];

  mc_line_xfer #(
    .AW(AW),
    .LW(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr),
    .buf_waddr (buf_waddr),
    .buf_wdata (buf_wdata),
    .buf_we    (buf_we),
    .buf_raddr (buf_raddr),
    .buf_rdata (buf_rdata),
    .mi_addr   (mi_addr),
    .mi_len    (mi_len),
    .mi_rw     (mi_rw),
    .mi_valid  (mi_valid),
    .mi_ready  (mi_ready),
    .mi_wdata  (mi_wdata),
    .mi_wack   (mi_wack),
    .mi_wlast  (mi_wlast),
    .mi_rdata  (mi_rdata),
    .mi_rstb   (mi_rstb),
    .mi_rlast  (mi_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clientWrite(input int a, input logic [31:0] d);
    buf_we    = 1'b1;
    buf_waddr = LW'(a);
    buf_wdata = d;
    tick();
    buf_we    = 1'b0;
    refBuf[a] = d;
  endtask

  task automatic checkBuffer(input string tag);
    for (int i = 0; i < WORDS; i++) begin
      buf_raddr = LW'(i);
      tick();
      checkOutput($sformatf("%s_buf%0d", tag, i), buf_rdata, refBuf[i]);
    end
  endtask

  // Present a request, hold mi_ready low for readyDelay cycles, then accept.
  task automatic issueRequest(input bit rw, input logic [AW-LW-1:0] line, input int readyDelay,
                              input bit holdValid, input bit nextRw, input logic [AW-LW-1:0] nextLine);
    logic [AW-1:0] expAddr;
    expAddr   = AW'(32'(line) * WORDS);
    req_valid = 1'b1;
    req_addr  = line;
    req_rw    = rw;
    checkOutput("reqReadyIdle", 32'(req_ready), 32'd1);
    tick();
    if (holdValid) begin
      req_rw   = nextRw;
      req_addr = nextLine;
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 0; c <= readyDelay; c++) begin
      checkOutput("miValidCmd", 32'(mi_valid), 32'd1);
      checkOutput("miAddrCmd", 32'(mi_addr), 32'(expAddr));
      checkOutput("miLenCmd", 32'(mi_len), 32'(WORDS - 1));
      checkOutput("miRwCmd", 32'(mi_rw), 32'(rw));
      checkOutput("reqReadyCmd", 32'(req_ready), 32'd0);
      if (c == readyDelay) mi_ready = 1'b1;
      tick();
    end
    mi_ready = 1'b0;
    checkOutput("miValidAfterAccept", 32'(mi_valid), 32'd0);
  endtask

  task automatic finishChecks(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_miValidInDone"}, 32'(mi_valid), 32'd0);
    checkOutput({tag, "_reqReadyInDone"}, 32'(req_ready), 32'd0);
    tick();
    checkOutput({tag, "_doneCleared"}, 32'(done), 32'd0);
    checkOutput({tag, "_reqReadyBack"}, 32'(req_ready), 32'd1);
  endtask

  // Controller side of a write burst; delay < 0 picks a random 0..2 per beat.
  task automatic writeBeats(input logic [AW-LW-1:0] line, input int delay, input bit badFinal);
    int d;
    int base;
    base = int'(line) * WORDS;
    for (int i = 0; i < WORDS; i++) begin
      d = (delay < 0) ? int'($urandom_range(0, 2)) : delay;
      repeat (d) tick();
      if (badFinal && i == WORDS - 1) begin
        mi_wack  = 1'b1;
        mi_wlast = 1'b0;
        tick();
        mi_wack  = 1'b0;
        checkOutput("errNoWlast", 32'(err), 32'd1);
        checkOutput("doneHeldNoWlast", 32'(done), 32'd0);
      end
      mi_wack  = 1'b1;
      mi_wlast = (i == WORDS - 1);
      checkOutput($sformatf("miWdata%0d", i), mi_wdata, refBuf[i]);
      memModel[base + i] = mi_wdata;
      tick();
      mi_wack  = 1'b0;
      mi_wlast = 1'b0;
      if (i < WORDS - 1) checkOutput("doneEarlyW", 32'(done), 32'd0);
    end
    finishChecks("wr");
  endtask

  // Controller side of a read burst. gapBefore inserts one idle cycle before
  // that beat index; badBeat sends a premature rlast first; stopAfter < WORDS
  // returns early (for mid-transfer reset).
  task automatic readBeats(input int firstDelay, input int gapBefore, input int badBeat,
                           input int stopAfter, input bit randGaps);
    int d;
    logic [31:0] data;
    for (int i = 0; i < stopAfter; i++) begin
      if (i == 0) d = firstDelay;
      else if (i == gapBefore) d = 1;
      else d = randGaps ? int'($urandom_range(0, 2)) : 0;
      repeat (d) begin
        buf_we    = 1'b1;
        buf_waddr = LW'($urandom);
        buf_wdata = $urandom;
        tick();
      end
      buf_we = 1'b0;
      if (i == badBeat) begin
        mi_rstb  = 1'b1;
        mi_rlast = 1'b1;
        mi_rdata = $urandom;
        tick();
        mi_rstb  = 1'b0;
        mi_rlast = 1'b0;
        checkOutput("errEarlyRlast", 32'(err), 32'd1);
        checkOutput("doneHeldBadBeat", 32'(done), 32'd0);
      end
      data      = $urandom;
      mi_rstb   = 1'b1;
      mi_rlast  = (i == WORDS - 1);
      mi_rdata  = data;
      buf_we    = 1'b1;
      buf_waddr = LW'($urandom);
      buf_wdata = ~data;
      tick();
      mi_rstb   = 1'b0;
      mi_rlast  = 1'b0;
      buf_we    = 1'b0;
      refBuf[i] = data;
      if (i < WORDS - 1) checkOutput("doneEarlyR", 32'(done), 32'd0);
    end
    if (stopAfter == WORDS) finishChecks("rd");
  endtask

  initial begin
    logic [AW-LW-1:0] lineA;
    logic [AW-LW-1:0] lineB;
    bit               rw;

    rst = 1'b1; req_addr = '0; req_rw = 1'b0; req_valid = 1'b0; err_clr = 1'b0;
    buf_waddr = '0; buf_wdata = '0; buf_we = 1'b0; buf_raddr = '0;
    mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0; mi_rdata = '0;
    mi_rstb = 1'b0; mi_rlast = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rstReqReady", 32'(req_ready), 32'd1);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstMiValid", 32'(mi_valid), 32'd0);

    $display("[TB] preload and write line 0x40");
    for (int i = 0; i < WORDS; i++) clientWrite(i, 32'h100 + 32'(i));
    checkBuffer("preload");
    issueRequest(1'b0, 17'h40, 0, 1'b0, 1'b0, '0);
    writeBeats(17'h40, 2, 1'b0);
    for (int i = 0; i < WORDS; i++)
      checkOutput($sformatf("mem%0h", 32'h200 + 32'(i)), memModel[32'h200 + i], 32'h100 + 32'(i));
    checkOutput("errAfterWrite", 32'(err), 32'd0);

    $display("[TB] read line 0x40 with delayed first beat and gap");
    issueRequest(1'b1, 17'h40, 0, 1'b0, 1'b0, '0);
    readBeats(6, 3, -1, WORDS, 1'b0);
    checkBuffer("read1");
    checkOutput("errAfterRead", 32'(err), 32'd0);

    $display("[TB] command held while mi_ready low");
    lineA = AW'($urandom_range(0, 2**(AW-LW) - 1));
    issueRequest(1'b0, lineA, 5, 1'b0, 1'b0, '0);
    writeBeats(lineA, -1, 1'b0);

    $display("[TB] reset in the middle of a read");
    lineA = AW'($urandom_range(0, 2**(AW-LW) - 1));
    issueRequest(1'b1, lineA, 0, 1'b0, 1'b0, '0);
    readBeats(0, -1, -1, 4, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstReqReady", 32'(req_ready), 32'd1);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstErr", 32'(err), 32'd0);
    mi_rstb  = 1'b1;
    mi_rdata = 32'hDEAD_BEEF;
    tick();
    mi_rstb  = 1'b0;
    checkOutput("trailingRstbErr", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("errClrAfterTrailing", 32'(err), 32'd0);
    checkBuffer("afterRst");
    issueRequest(1'b1, lineA, 1, 1'b0, 1'b0, '0);
    readBeats(2, -1, -1, WORDS, 1'b1);
    checkBuffer("readAfterRst");

    $display("[TB] premature rlast on beat 5");
    issueRequest(1'b1, lineA, 0, 1'b0, 1'b0, '0);
    readBeats(1, -1, 4, WORDS, 1'b1);
    checkOutput("errSticky", 32'(err), 32'd1);
    checkBuffer("afterBadRlast");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("errCleared", 32'(err), 32'd0);

    $display("[TB] error and clear in the same cycle");
    mi_wack = 1'b1;
    err_clr = 1'b1;
    tick();
    mi_wack = 1'b0;
    checkOutput("setWinsOverClr", 32'(err), 32'd1);
    checkOutput("strayWackNoStart", 32'(req_ready), 32'd1);
    tick();
    checkOutput("clrAlone", 32'(err), 32'd0);
    err_clr = 1'b0;

    $display("[TB] final write beat missing wlast");
    for (int i = 0; i < WORDS; i++) clientWrite(i, $urandom);
    lineA = AW'($urandom_range(0, 2**(AW-LW) - 1));
    issueRequest(1'b0, lineA, 0, 1'b0, 1'b0, '0);
    writeBeats(lineA, -1, 1'b1);
    checkOutput("errAfterNoWlast", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    $display("[TB] back-to-back write then read");
    lineA = AW'($urandom_range(0, 2**(AW-LW) - 1));
    lineB = AW'($urandom_range(0, 2**(AW-LW) - 1));
    issueRequest(1'b0, lineA, 1, 1'b1, 1'b1, lineB);
    writeBeats(lineA, -1, 1'b0);
    issueRequest(1'b1, lineB, 0, 1'b0, 1'b0, '0);
    readBeats(1, -1, -1, WORDS, 1'b1);
    checkBuffer("b2b");
    checkOutput("errB2b", 32'(err), 32'd0);

    $display("[TB] random transfers");
    for (int n = 0; n < 4; n++) begin
      rw    = 1'($urandom_range(0, 1));
      lineA = AW'($urandom_range(0, 2**(AW-LW) - 1));
      clientWrite(int'($urandom_range(0, WORDS - 1)), $urandom);
      issueRequest(rw, lineA, int'($urandom_range(0, 3)), 1'b0, 1'b0, '0);
      if (rw) readBeats(int'($urandom_range(0, 3)), -1, -1, WORDS, 1'b1);
      else    writeBeats(lineA, -1, 1'b0);
      checkBuffer($sformatf("rand%0d", n));
    end
    checkOutput("errFinal", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_line_xfer.md
MC_LINE_XFER -- requirements
Module: mc_line_xfer

Interface
REQ-001 Parameter AW, default 20: word-address width of the memory controller port.
REQ-002 Parameter LW, default 3: log2 of line length in 32-bit words; legal range 1..7, giving 2..128 words per line.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_addr  in  AW-LW  line address; the word address is {req_addr, LW zeros}.
REQ-006 req_rw  in  1  1 = read line from memory into buffer; 0 = write buffer to memory.
REQ-007 req_valid / req_ready  in / out  1 each  request handshake; transfer when both are high.
REQ-008 done  out  1  one-cycle pulse when a transfer completes.
REQ-009 err  out  1  sticky protocol-error flag.
REQ-010 err_clr  in  1  clears err.
REQ-011 buf_waddr, buf_wdata, buf_we  in  LW, 32, 1  client write port into the line buffer.
REQ-012 buf_raddr  in  LW  client read address; buf_rdata  out  32  registered read data.
REQ-013 Memory controller port: mi_addr (out, AW), mi_len (out, 7), mi_rw (out, 1), mi_valid (out, 1), mi_ready (in, 1), mi_wdata (out, 32), mi_wack (in), mi_wlast (in), mi_rdata (in, 32), mi_rstb (in), mi_rlast (in).

Function
REQ-014 States: IDLE, CMD, WDATA, RDATA, DONE.
REQ-015 In IDLE, req_ready is 1; in every other state it is 0.
REQ-016 IDLE -> CMD on req_valid; the same edge latches req_addr and req_rw.
REQ-017 In CMD, the block drives the command fields as follows:
- mi_valid = 1
- mi_addr = {latched addr, LW zeros}
- mi_len = 2^LW - 1 (the controller performs mi_len+1 beats)
- mi_rw = latched rw
REQ-018 The command fields are held stable until mi_ready is seen; on mi_ready, CMD -> RDATA if rw = 1, else CMD -> WDATA.
REQ-019 A beat counter (LW+1 bits) is cleared on entry to CMD.
REQ-020 WDATA: mi_wdata is the combinational buffer read at the counter's low LW bits, so it is valid in the same cycle as mi_wack; the counter increments on each mi_wack.
REQ-021 WDATA -> DONE on the mi_wack that carries the 2^LW-th beat.
REQ-022 RDATA: on each mi_rstb, mi_rdata is written to buffer[counter] and the counter increments; RDATA -> DONE on the 2^LW-th beat.
REQ-023 DONE: done = 1 for exactly one cycle, then DONE -> IDLE; the next request is accepted in the cycle after done at the earliest.
REQ-024 err is set when any of the following occurs:
- mi_rlast (with mi_rstb) or mi_wlast (with mi_wack) is asserted on a beat other than the final one
- the final beat arrives without its last flag
- mi_rstb or mi_wack is seen in IDLE, CMD or DONE
REQ-025 Beats flagged as errors in REQ-024 do not write the buffer, do not move the counter and do not change state.
REQ-026 err_clr clears err; if err_clr and a new error occur in the same cycle, err ends the cycle set (set wins).
REQ-027 Client buffer writes (buf_we) take effect only in IDLE and are ignored otherwise.
REQ-028 buf_rdata = buffer[buf_raddr] one cycle later, in any state.
REQ-029 A client write and a client read to the same address in the same cycle return the old data.
REQ-030 In RDATA, client reads are allowed but return undefined data for words not yet filled.
REQ-031 mi_valid, done and the state depend only on registered state (no combinational path from mi_ready).

Reset
REQ-032 rst forces the following, regardless of the current state, including mid-transfer: state = IDLE, mi_valid = 0, done = 0, err = 0, counter = 0.
REQ-033 Buffer contents and buf_rdata are not reset.
REQ-034 mi_addr, mi_len, mi_rw and mi_wdata are don't-care while mi_valid = 0 and outside WDATA.
REQ-035 Memory-port strobes that arrive after a mid-transfer reset are treated per REQ-024.

Structure
REQ-036 The state encodings and the mi_len computation function belong in the shared memcache package, alongside the controller port width constants.
REQ-037 The line buffer is one sub-module, mc_line_buf: 2^LW x 32, one write port muxed between the client and mi_rdata, one combinational read port (write data) and one registered read port (client).

Verification
REQ-038 LW=3, buffer preloaded 0..7 with 0x100+i, write request at line 0x40, controller model with a 2-cycle wack delay -> mi_addr=0x200, mi_len=7, eight wacks, memory holds 0x100..0x107 at 0x200..0x207, one done pulse, err=0.
REQ-039 Read request at line 0x40 with rstb delayed 6 cycles and a one-cycle gap after beat 3 -> buffer[i] = 0x100+i, done on the cycle after the 8th rstb.
REQ-040 mi_ready held low for 5 cycles in CMD -> mi_valid stays high and fields stay stable; no wdata consumed before acceptance.
REQ-041 rst asserted after the 4th rstb of a read -> next cycle req_ready=1, done=0; trailing rstb sets err; a new read then completes with correct data.
REQ-042 mi_rlast asserted on beat 5 of 8 -> err=1 and remains set; err_clr pulse -> err=0.
REQ-043 Back-to-back write then read, with req_valid held high -> second request accepted the cycle after done, and mi_valid is never asserted during DONE.
